acc_mod2nm1: RTL and testbench

Streaming modulo (2^n − 1) accumulator: sums or subtracts a block of width-bit operands, one per cycle, in 1's-complement arithmetic using an end-around-carry parallel-prefix adder core. It is the sequential successor of the combinational mod (2^n − 1) adders in the arithmetic library. It adds valid/ready handshaking, per-operand add/subtract, selectable zero representation and an operand counter. It sits in residue-number-system datapaths and checksum engines, between an operand source and a residue consumer.

---
 rtl/acc_mod2nm1.sv | 139 +++++++++++++
 tb/tb_acc_mod2nm1.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_mod2nm1.sv
// Streaming modulo (2^Width - 1) accumulator with valid/ready handshake.
// Operands are summed (or subtracted as 1's complement) with an end-around-carry
// parallel-prefix adder; the residue and operand count are emitted once per block.
module acc_mod2nm1 #(
    parameter int unsigned Width      = 8,
    // 0 = serial prefix chain, nonzero = Kogge-Stone log-depth prefix tree
    parameter int unsigned Speed      = 1,
    // 1 = all-ones is never produced (single zero), 0 = all-ones is a legal zero
    parameter bit          SingleZero = 1'b1,
    parameter int unsigned MaxOps     = 256,
    localparam int unsigned CntWidth  = $clog2(MaxOps + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [Width-1:0]    in_data_i,
    input  logic                in_sub_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    out_data_o,
    output logic [CntWidth-1:0] out_count_o
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e              state_q;
    logic [Width-1:0]    acc_q;
    logic [CntWidth-1:0] cnt_q;
    logic                out_valid_q;
    logic [Width-1:0]    out_data_q;
    logic [CntWidth-1:0] out_count_q;

    logic                in_fire;
    logic                out_fire;
    logic [Width-1:0]    op_y;
    logic [Width-1:0]    base;
    logic [Width-1:0]    gen;
    logic [Width-1:0]    prop;
    logic [Width-1:0]    grp_g;
    logic [Width-1:0]    grp_p;
    logic [Width-1:0]    carry;
    logic [Width-1:0]    sum;
    logic                carry_in;
    logic [CntWidth-1:0] cnt_d;

    assign in_ready_o = ~out_valid_q | out_ready_i;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = out_valid_q & out_ready_i;

    // Subtraction adds the 1's complement; a new block always starts from zero.
    assign op_y = in_sub_i ? ~in_data_i : in_data_i;
    assign base = (state_q == StAccum) ? acc_q : '0;
    assign gen  = base & op_y;
    assign prop = base ^ op_y;

    // Group generate/propagate over bits [i:0]
    if (Speed != 0) begin : g_kogge_stone
        always_comb begin
            grp_g = gen;
            grp_p = prop;
            for (int d = 1; d < int'(Width); d = d * 2) begin
                // Descending index keeps the lower, not-yet-updated spans for this level
                for (int i = int'(Width) - 1; i >= d; i--) begin
                    grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
                    grp_p[i] = grp_p[i] & grp_p[i-d];
                end
            end
        end
    end else begin : g_serial
        always_comb begin
            grp_g = gen;
            grp_p = prop;
            for (int i = 1; i < int'(Width); i++) begin
                grp_g[i] = gen[i] | (prop[i] & grp_g[i-1]);
                grp_p[i] = prop[i] & grp_p[i-1];
            end
        end
    end

    // Feeding full propagate back as carry turns an all-ones sum into zero.
    assign carry_in = SingleZero ? (grp_g[Width-1] | grp_p[Width-1]) : grp_g[Width-1];

    // End-around carry resolved in one step from the group terms
    always_comb begin
        carry[0] = carry_in;
        for (int i = 1; i < int'(Width); i++) begin
            carry[i] = grp_g[i-1] | (grp_p[i-1] & carry_in);
        end
    end

    assign sum = prop ^ carry;

    // Operand counter: restart at 1 on a block's first operand, saturate at MaxOps
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != StAccum) begin
            cnt_d = CntWidth'(1);
        end else if (cnt_q != CntWidth'(MaxOps)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    // Block sequencing, accumulator and registered result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (in_fire) begin
                acc_q <= sum;
                cnt_q <= cnt_d;
                if (in_last_i) begin
                    state_q     <= StHold;
                    out_valid_q <= 1'b1;
                    out_data_q  <= sum;
                    out_count_q <= cnt_d;
                end else begin
                    state_q <= StAccum;
                end
            end else if (out_fire) begin
                state_q <= StIdle;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;

endmodule

// File: tb/tb_acc_mod2nm1.sv
// Self-checking bench for acc_mod2nm1: two instances share one stimulus stream,
// a single-zero/MaxOps=256 one and a double-zero/MaxOps=4 one.
module tb_acc_mod2nm1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_sub = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready_a, in_ready_b;
    logic       out_valid_a, out_valid_b;
    logic [7:0] out_data_a, out_data_b;
    logic [8:0] out_count_a;
    logic [2:0] out_count_b;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit rnd_mode = 1'b0;

    // Reference model state
    bit m_active = 1'b0;
    int m_sum = 0;
    int m_acc0 = 0;
    int m_n = 0;
    bit exp_valid = 1'b0;
    int exp_data_a = 0;
    int exp_data_b = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    always #5 clk = ~clk;

    acc_mod2nm1 #(
        .Width(8), .Speed(1), .SingleZero(1'b1), .MaxOps(256)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
        .in_data_i(in_data), .in_sub_i(in_sub), .in_last_i(in_last),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready),
        .out_data_o(out_data_a), .out_count_o(out_count_a)
    );

    acc_mod2nm1 #(
        .Width(8), .Speed(0), .SingleZero(1'b0), .MaxOps(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .in_data_i(in_data), .in_sub_i(in_sub), .in_last_i(in_last),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready),
        .out_data_o(out_data_b), .out_count_o(out_count_b)
    );

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Model: signed running sum mod 255 for single zero; 1's-complement word adds
    // (wrap when above 255) for double zero.
    always @(posedge clk) begin : model_p
        int s;
        int a0;
        int n;
        bit rdy;
        if (rst) begin
            m_active   <= 1'b0;
            m_sum      <= 0;
            m_acc0     <= 0;
            m_n        <= 0;
            exp_valid  <= 1'b0;
            exp_data_a <= 0;
            exp_data_b <= 0;
            exp_cnt_a  <= 0;
            exp_cnt_b  <= 0;
        end else begin
            rdy = !exp_valid || out_ready;
            if (exp_valid && out_ready) exp_valid <= 1'b0;
            if (in_valid && rdy) begin
                s  = m_active ? m_sum : 0;
                a0 = m_active ? m_acc0 : 0;
                n  = m_active ? m_n : 0;
                s  = s + (in_sub ? -int'(in_data) : int'(in_data));
                a0 = a0 + (in_sub ? 255 - int'(in_data) : int'(in_data));
                if (a0 > 255) a0 = a0 - 255;
                n  = n + 1;
                m_sum  <= s;
                m_acc0 <= a0;
                m_n    <= n;
                if (in_last) begin
                    m_active   <= 1'b0;
                    exp_valid  <= 1'b1;
                    exp_data_a <= ((s % 255) + 255) % 255;
                    exp_data_b <= a0;
                    exp_cnt_a  <= (n > 256) ? 256 : n;
                    exp_cnt_b  <= (n > 4) ? 4 : n;
                end else begin
                    m_active <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready_a", int'(in_ready_a), int'(!exp_valid || out_ready));
            check("in_ready_b", int'(in_ready_b), int'(!exp_valid || out_ready));
            check("out_valid_a", int'(out_valid_a), int'(exp_valid));
            check("out_valid_b", int'(out_valid_b), int'(exp_valid));
            if (exp_valid) begin
                check("out_data_a", int'(out_data_a), exp_data_a);
                check("out_data_b", int'(out_data_b), exp_data_b);
                check("out_count_a", int'(out_count_a), exp_cnt_a);
                check("out_count_b", int'(out_count_b), exp_cnt_b);
            end
        end
    end

    // Offer one operand; returns just after the edge that transferred it.
    task automatic send(input logic [7:0] x, input logic s, input logic l);
        bit done;
        int k;
        done = 1'b0;
        k = 0;
        in_valid = 1'b1;
        in_data = x;
        in_sub = s;
        in_last = l;
        while (!done) begin
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (!exp_valid || out_ready) done = 1'b1;
            @(posedge clk);
            #1;
            k++;
            if (!done && k > 50) begin
                check("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Literal expectations for the result just produced
    task automatic expect_result(input string tag, input int da, input int db,
                                 input int ca, input int cb);
        @(negedge clk);
        check({tag, "_valid"}, int'(out_valid_a), 1);
        check({tag, "_data_a"}, int'(out_data_a), da);
        check({tag, "_data_b"}, int'(out_data_b), db);
        check({tag, "_cnt_a"}, int'(out_count_a), ca);
        check({tag, "_cnt_b"}, int'(out_count_b), cb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", int'(out_valid_a), 0);
        check("rst_data", int'(out_data_a), 0);
        check("rst_count", int'(out_count_a), 0);
        check("rst_ready", int'(in_ready_a), 1);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        out_ready = 1'b1;
        send(8'd200, 1'b0, 1'b0);
        send(8'd100, 1'b0, 1'b1);
        expect_result("sum45", 45, 45, 2, 2);

        send(8'd128, 1'b0, 1'b0);
        send(8'd127, 1'b0, 1'b1);
        expect_result("allones", 0, 255, 2, 2);

        send(8'd5, 1'b0, 1'b0);
        send(8'd5, 1'b1, 1'b1);
        expect_result("negzero", 0, 255, 2, 2);

        send(8'd3, 1'b0, 1'b0);
        send(8'd10, 1'b1, 1'b1);
        expect_result("neg7", 248, 248, 2, 2);

        // Backpressure: result 15 held while the next block's operand waits
        out_ready = 1'b0;
        send(8'd7, 1'b0, 1'b0);
        send(8'd8, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data = 8'd1;
        in_sub = 1'b0;
        in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", int'(in_ready_a), 0);
            check("bp_data", int'(out_data_a), 15);
            check("bp_count", int'(out_count_a), 2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", int'(in_ready_a), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        expect_result("single", 1, 1, 1, 1);

        // Reset mid-block discards the partial sum
        send(8'd1, 1'b0, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", int'(out_valid_a), 0);
        @(posedge clk);
        #1;
        send(8'd10, 1'b0, 1'b0);
        send(8'd20, 1'b0, 1'b1);
        expect_result("after_rst", 30, 30, 2, 2);

        // Counter saturation on the MaxOps=4 instance
        for (int i = 0; i < 6; i++) send(8'd1, 1'b0, (i == 5));
        expect_result("sat", 6, 6, 6, 4);

        // Randomized blocks with random backpressure and gaps
        rnd_mode = 1'b1;
        for (int b = 0; b < 80; b++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 20))
                                              : int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), (i == len - 1));
                if ($urandom_range(0, 4) == 0) begin
                    out_ready = ($urandom_range(0, 1) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
